hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised data-hazard unit sitting between decode and execute of the RV32I pipeline. It tracks destination registers of up to `DEPTH` in-flight instructions in a shift scoreboard, stalls decode on unresolved RAW hazards, and optionally emits operand-forwarding selects instead of stalling. It also inserts NOP bubbles on stall and on a two-cycle branch flush.

## Interface
- `DEPTH`, 3: pipeline stages after issue before a result is readable from the register file (1..7).
- `FWD`, 0: 0 = stall on every RAW hazard; 1 = forward from stages, stall only on load-use.
- `FW`, `$clog2(DEPTH+1)`: width of forward selects (derived, not overridden).
- `clk  in  1`: single clock, rising edge.
- `rst  in  1`: reset, synchronous, active-high.
- `instr  in  32`: instruction currently in decode.
- `br  in  1`: branch-taken flush pulse.
- `stall_o  out  1`: hold PC and decode register this cycle.
- `hz_instr_o  out  32`: registered instruction issued to execute; 32'h0 = bubble.
- `fwd1_o  out  FW`: rs1 source for `instr`; 0 = register file, k = scoreboard entry k-1.
- `fwd2_o  out  FW`: rs2 source, same encoding.

## Operation
- Operand use by opcode: rs1 for JALR, BRANCH, LOAD, STORE, OP-IMM, OP; rs2 for BRANCH, STORE, OP; rd written by LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP. FENCE and SYSTEM neither read nor write. x0 never hazards.
- Scoreboard: `DEPTH` entries {valid, rd[4:0], is_load}. Entry 0 describes `hz_instr_o`. Each clock entry k moves to k+1 and entry `DEPTH-1` retires. The register file is write-first, so a retired entry causes no hazard.
- New entry 0: the issued instruction's rd if it writes a nonzero rd. Otherwise valid=0.
- Match: operand used, rs≠0, rs==entry.rd, entry.valid. The lowest-index (youngest) match wins.
- `FWD`=0: any match on either operand asserts `stall_o`. `fwd*_o` is constant 0.
- `FWD`=1: a match at entry 0 with is_load=1 asserts `stall_o`. Every other match sets `fwd*_o` = index+1 with no stall.
- Flush: `br_d` is `br` delayed one cycle. While `br|br_d`, `stall_o`=0 and the next `hz_instr_o`=0. Flush wins over stall.
- Issue rule on each clock:
  - flush → `hz_instr_o`<=0;
  - else stall → `hz_instr_o`<=0 and upstream holds `instr`;
  - else `hz_instr_o`<=`instr`.
- Bubbles and flushed slots enter the scoreboard as valid=0.

## Timing
- Issue latency: 1 cycle, `instr` → `hz_instr_o`.
- `stall_o` and `fwd*_o` are combinational from `instr` plus registered state, valid in the same cycle.
- Non-forwarded RAW distance d (1..DEPTH) gives DEPTH−d+1 stall cycles. Load-use with `FWD`=1 gives exactly 1 stall cycle.
- Reset, one cycle: all entries invalid, `hz_instr_o`=0, `br_d`=0.
- While `rst`=1, `stall_o`=0 and `fwd*_o`=0.
- Reset asserted mid-stall: the next cycle is clean, with no residual stall.
- `br` on consecutive cycles extends the flush. Each pulse covers its own cycle and the following one.

## Structure
- `hazard_pkg`: opcode localparams, `NOP`=32'h0, and functions `uses_rs1`, `uses_rs2`, `writes_rd`, `is_load`. These are shared with decode.
- Sub-module `hazard_fwd_sel`: parametrised on `DEPTH`. Takes rs plus the entry arrays and returns {hit, is_load_hit_at_0, index}. Instantiated once per source operand.
- Top level holds the scoreboard shift register, `br_d`, the issue register and the stall/flush muxing.

## Test plan
- Reset: `rst` high 2 cycles with `instr`=32'h00528333 → `hz_instr_o`=0, `stall_o`=0, `fwd1_o`=`fwd2_o`=0.
- `FWD`=0, `DEPTH`=3: issue 32'h00100293 (addi x5,x0,1), then 32'h00528333 (add x6,x5,x5) → `stall_o`=1 for 3 cycles, 3 zero bubbles, then `hz_instr_o`=32'h00528333.
- `FWD`=1: same sequence → no stall, `fwd1_o`=`fwd2_o`=1 while add is in decode.
- `FWD`=1 load-use: 32'h0000a283 (lw x5,0(x1)), then 32'h00528333 → 1 stall cycle with a bubble, then `fwd1_o`=`fwd2_o`=2 and add issues.
- x0: 32'h00000013, then 32'h00000333 → no stall, forward selects 0.
- Flush during stall: assert `br` for 1 cycle in the middle of the stall from test 2 → `stall_o`=0 for that cycle and the next, and `hz_instr_o`=0 for 2 issue cycles.

Source files
------------

// File: rtl/hazard_pkg.sv
// Opcode constants and operand-usage decode helpers for RV32I hazard tracking.
// Shared between decode and the hazard scoreboard.
package hazard_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // All-zero word is the bubble encoding on the issue register.
    localparam logic [31:0] NOP = 32'h0000_0000;

    // Register index width.
    localparam int RW = 5;

    function automatic logic uses_rs1(input logic [6:0] opc);
        return (opc == OPC_JALR)  || (opc == OPC_BRANCH) || (opc == OPC_LOAD) ||
               (opc == OPC_STORE) || (opc == OPC_OP_IMM) || (opc == OPC_OP);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opc);
        return (opc == OPC_BRANCH) || (opc == OPC_STORE) || (opc == OPC_OP);
    endfunction

    function automatic logic writes_rd(input logic [6:0] opc);
        return (opc == OPC_LUI)  || (opc == OPC_AUIPC)  || (opc == OPC_JAL) ||
               (opc == OPC_JALR) || (opc == OPC_LOAD)   || (opc == OPC_OP_IMM) ||
               (opc == OPC_OP);
    endfunction

    function automatic logic is_load(input logic [6:0] opc);
        return (opc == OPC_LOAD);
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand scoreboard lookup: finds the youngest valid entry whose rd
// matches the source register, and flags a load sitting in entry 0.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int FW    = $clog2(DEPTH + 1)
) (
    input  logic [RW-1:0]             rs_i,
    input  logic                      use_i,
    input  logic [DEPTH-1:0]          valid_i,
    input  logic [DEPTH-1:0][RW-1:0]  rd_i,
    input  logic [DEPTH-1:0]          ld_i,
    output logic                      hit_o,
    output logic                      load_hit0_o,
    output logic [FW-1:0]             idx_o
);

    // Scan oldest to youngest so the lowest-index match is the one that sticks.
    always_comb begin
        hit_o       = 1'b0;
        load_hit0_o = 1'b0;
        idx_o       = '0;
        if (use_i && (rs_i != '0)) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (valid_i[k] && (rd_i[k] == rs_i)) begin
                    hit_o = 1'b1;
                    idx_o = FW'(k);
                end
            end
            load_hit0_o = valid_i[0] && (rd_i[0] == rs_i) && ld_i[0];
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode/execute data-hazard unit: shift scoreboard of in-flight rd values,
// RAW stall or forward-select generation, and bubble/flush insertion on issue.
//
// Flow control: stall_o is a combinational "hold" back to decode. While it is
// high the PC and decode register keep `instr` and a bubble is issued; the
// instruction is accepted on the first clock edge where stall_o is low and no
// flush is active. Flush cycles discard `instr` without holding it.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int FWD   = 0,
    parameter int FW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   instr,
    input  logic          br,
    output logic          stall_o,
    output logic [31:0]   hz_instr_o,
    output logic [FW-1:0] fwd1_o,
    output logic [FW-1:0] fwd2_o
);

    logic [DEPTH-1:0]         sb_valid_q, sb_valid_d;
    logic [DEPTH-1:0][RW-1:0] sb_rd_q,    sb_rd_d;
    logic [DEPTH-1:0]         sb_ld_q,    sb_ld_d;
    logic                     br_d_q;
    logic [31:0]              hz_instr_q, hz_instr_d;

    logic          hit1, hit2, lh1, lh2;
    logic [FW-1:0] idx1, idx2;
    logic          flush, stall_raw;

    hazard_fwd_sel #(.DEPTH(DEPTH), .FW(FW)) u_sel1 (
        .rs_i        (instr[19:15]),
        .use_i       (uses_rs1(instr[6:0])),
        .valid_i     (sb_valid_q),
        .rd_i        (sb_rd_q),
        .ld_i        (sb_ld_q),
        .hit_o       (hit1),
        .load_hit0_o (lh1),
        .idx_o       (idx1)
    );

    hazard_fwd_sel #(.DEPTH(DEPTH), .FW(FW)) u_sel2 (
        .rs_i        (instr[24:20]),
        .use_i       (uses_rs2(instr[6:0])),
        .valid_i     (sb_valid_q),
        .rd_i        (sb_rd_q),
        .ld_i        (sb_ld_q),
        .hit_o       (hit2),
        .load_hit0_o (lh2),
        .idx_o       (idx2)
    );

    // Stall decision: any hit without forwarding, only load-use with it; flush and reset mask it.
    always_comb begin
        flush = br | br_d_q;
        if (FWD != 0) begin
            stall_raw = lh1 | lh2;
        end else begin
            stall_raw = hit1 | hit2;
        end
        stall_o = !rst && !flush && stall_raw;
    end

    // Forward selects: entry index + 1 for non-load-use hits, 0 means register file.
    always_comb begin
        fwd1_o = '0;
        fwd2_o = '0;
        if ((FWD != 0) && !rst) begin
            if (hit1 && !lh1) begin
                fwd1_o = idx1 + FW'(1);
            end
            if (hit2 && !lh2) begin
                fwd2_o = idx2 + FW'(1);
            end
        end
    end

    // Next issued word and the scoreboard shift with the new entry 0 derived from it.
    always_comb begin
        hz_instr_d = (flush || stall_raw) ? NOP : instr;
        for (int k = DEPTH - 1; k >= 1; k--) begin
            sb_valid_d[k] = sb_valid_q[k-1];
            sb_rd_d[k]    = sb_rd_q[k-1];
            sb_ld_d[k]    = sb_ld_q[k-1];
        end
        sb_valid_d[0] = writes_rd(hz_instr_d[6:0]) && (hz_instr_d[11:7] != '0);
        sb_rd_d[0]    = hz_instr_d[11:7];
        sb_ld_d[0]    = is_load(hz_instr_d[6:0]);
    end

    // State registers: scoreboard, delayed branch flag and issue register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_valid_q <= '0;
            sb_rd_q    <= '0;
            sb_ld_q    <= '0;
            br_d_q     <= 1'b0;
            hz_instr_q <= NOP;
        end else begin
            sb_valid_q <= sb_valid_d;
            sb_rd_q    <= sb_rd_d;
            sb_ld_q    <= sb_ld_d;
            br_d_q     <= br;
            hz_instr_q <= hz_instr_d;
        end
    end

    assign hz_instr_o = hz_instr_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: one instance without forwarding and
// one with forwarding, both DEPTH=3, driven from per-cycle vector tables.
module tb_hazard_scoreboard;

    localparam int FW = 2;

    localparam logic [31:0] I_ADDI5  = 32'h00100293; // addi x5,x0,1
    localparam logic [31:0] I_ADD6   = 32'h00528333; // add  x6,x5,x5
    localparam logic [31:0] I_LW5    = 32'h0000a283; // lw   x5,0(x1)
    localparam logic [31:0] I_NOPI   = 32'h00000013; // addi x0,x0,0
    localparam logic [31:0] I_ADD600 = 32'h00000333; // add  x6,x0,x0
    localparam logic [31:0] I_ADDI6  = 32'h00200313; // addi x6,x0,2
    localparam logic [31:0] I_ADD7   = 32'h006283B3; // add  x7,x5,x6

    typedef struct {
        logic          rst;
        logic          br;
        logic [31:0]   instr;
        logic          chk_hz;
        logic          exp_stall;
        logic [31:0]   exp_hz;
        logic [FW-1:0] exp_f1;
        logic [FW-1:0] exp_f2;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst0, rst1, br0, br1;
    logic [31:0]   instr0, instr1;
    logic          stall0, stall1;
    logic [31:0]   hz0, hz1;
    logic [FW-1:0] f10, f20, f11, f21;

    int checks = 0;
    int errors = 0;

    vec_t v0[$];
    vec_t v1[$];

    // Clock
    always #5 clk = ~clk;

    hazard_scoreboard #(.DEPTH(3), .FWD(0)) u_nofwd (
        .clk(clk), .rst(rst0), .instr(instr0), .br(br0),
        .stall_o(stall0), .hz_instr_o(hz0), .fwd1_o(f10), .fwd2_o(f20)
    );

    hazard_scoreboard #(.DEPTH(3), .FWD(1)) u_fwd (
        .clk(clk), .rst(rst1), .instr(instr1), .br(br1),
        .stall_o(stall1), .hz_instr_o(hz1), .fwd1_o(f11), .fwd2_o(f21)
    );

    function automatic vec_t mk(input logic r, input logic b, input logic [31:0] i,
                                input logic ch, input logic s, input logic [31:0] h,
                                input logic [FW-1:0] a1, input logic [FW-1:0] a2);
        vec_t v;
        v.rst = r; v.br = b; v.instr = i; v.chk_hz = ch;
        v.exp_stall = s; v.exp_hz = h; v.exp_f1 = a1; v.exp_f2 = a2;
        return v;
    endfunction

    task automatic check(input string name, input int step, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
        end
    endtask

    // One vector = one clock cycle: drive, compare at negedge, advance past posedge.
    task automatic apply(input int inst, input vec_t v, input int step);
        if (inst == 0) begin
            rst0 = v.rst; br0 = v.br; instr0 = v.instr;
        end else begin
            rst1 = v.rst; br1 = v.br; instr1 = v.instr;
        end
        @(negedge clk);
        if (inst == 0) begin
            check("nofwd_stall", step, {31'b0, stall0}, {31'b0, v.exp_stall});
            check("nofwd_fwd1", step, {30'b0, f10}, {30'b0, v.exp_f1});
            check("nofwd_fwd2", step, {30'b0, f20}, {30'b0, v.exp_f2});
            if (v.chk_hz) check("nofwd_hz", step, hz0, v.exp_hz);
        end else begin
            check("fwd_stall", step, {31'b0, stall1}, {31'b0, v.exp_stall});
            check("fwd_fwd1", step, {30'b0, f11}, {30'b0, v.exp_f1});
            check("fwd_fwd2", step, {30'b0, f21}, {30'b0, v.exp_f2});
            if (v.chk_hz) check("fwd_hz", step, hz1, v.exp_hz);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt;
        rst0 = 1'b1; rst1 = 1'b1; br0 = 1'b0; br1 = 1'b0;
        instr0 = 32'h0; instr1 = 32'h0;

        // No-forwarding instance, one row per cycle.
        //          rst  br   instr     chk  stall hz        f1 f2
        v0.push_back(mk(1, 0, I_ADD6,   0, 0, 32'h0,   0, 0)); // reset cycle 1
        v0.push_back(mk(1, 0, I_ADD6,   1, 0, 32'h0,   0, 0)); // reset cycle 2
        v0.push_back(mk(0, 0, I_ADDI5,  1, 0, 32'h0,   0, 0));
        v0.push_back(mk(0, 0, I_ADD6,   1, 1, I_ADDI5, 0, 0)); // RAW d=1: 3 stalls
        v0.push_back(mk(0, 0, I_ADD6,   1, 1, 32'h0,   0, 0));
        v0.push_back(mk(0, 0, I_ADD6,   1, 1, 32'h0,   0, 0));
        v0.push_back(mk(0, 0, I_ADD6,   1, 0, 32'h0,   0, 0));
        v0.push_back(mk(0, 0, 32'h0,    1, 0, I_ADD6,  0, 0));
        v0.push_back(mk(0, 0, I_NOPI,   1, 0, 32'h0,   0, 0)); // x0 never hazards
        v0.push_back(mk(0, 0, I_ADD600, 1, 0, I_NOPI,  0, 0));
        v0.push_back(mk(0, 0, 32'h0,    1, 0, I_ADD600,0, 0));
        v0.push_back(mk(0, 0, I_ADDI5,  1, 0, 32'h0,   0, 0)); // flush during stall
        v0.push_back(mk(0, 0, I_ADD6,   1, 1, I_ADDI5, 0, 0));
        v0.push_back(mk(0, 1, I_ADD6,   1, 0, 32'h0,   0, 0));
        v0.push_back(mk(0, 0, I_ADD6,   1, 0, 32'h0,   0, 0));
        v0.push_back(mk(0, 0, I_ADD6,   1, 0, 32'h0,   0, 0));
        v0.push_back(mk(0, 0, 32'h0,    1, 0, I_ADD6,  0, 0));
        v0.push_back(mk(0, 1, I_ADDI5,  1, 0, 32'h0,   0, 0)); // back-to-back br
        v0.push_back(mk(0, 1, I_ADDI5,  1, 0, 32'h0,   0, 0));
        v0.push_back(mk(0, 0, I_ADDI5,  1, 0, 32'h0,   0, 0));
        v0.push_back(mk(0, 0, I_ADDI5,  1, 0, 32'h0,   0, 0));
        v0.push_back(mk(0, 0, 32'h0,    1, 0, I_ADDI5, 0, 0));
        v0.push_back(mk(0, 0, I_ADD6,   1, 1, 32'h0,   0, 0)); // reset mid-stall
        v0.push_back(mk(1, 0, I_ADD6,   1, 0, 32'h0,   0, 0));
        v0.push_back(mk(0, 0, I_ADD6,   1, 0, 32'h0,   0, 0));
        v0.push_back(mk(0, 0, 32'h0,    1, 0, I_ADD6,  0, 0));
        v0.push_back(mk(0, 0, I_ADDI5,  1, 0, 32'h0,   0, 0)); // RAW d=2: 2 stalls
        v0.push_back(mk(0, 0, I_NOPI,   1, 0, I_ADDI5, 0, 0));
        v0.push_back(mk(0, 0, I_ADD6,   1, 1, I_NOPI,  0, 0));
        v0.push_back(mk(0, 0, I_ADD6,   1, 1, 32'h0,   0, 0));
        v0.push_back(mk(0, 0, I_ADD6,   1, 0, 32'h0,   0, 0));
        v0.push_back(mk(0, 0, 32'h0,    1, 0, I_ADD6,  0, 0));

        // Forwarding instance.
        v1.push_back(mk(1, 0, I_ADD6,   0, 0, 32'h0,   0, 0));
        v1.push_back(mk(1, 0, I_ADD6,   1, 0, 32'h0,   0, 0));
        v1.push_back(mk(0, 0, I_ADDI5,  1, 0, 32'h0,   0, 0));
        v1.push_back(mk(0, 0, I_ADD6,   1, 0, I_ADDI5, 1, 1)); // forward from entry 0
        v1.push_back(mk(0, 0, 32'h0,    1, 0, I_ADD6,  0, 0));
        v1.push_back(mk(0, 0, I_LW5,    1, 0, 32'h0,   0, 0)); // load-use
        v1.push_back(mk(0, 0, I_ADD6,   1, 1, I_LW5,   0, 0));
        v1.push_back(mk(0, 0, I_ADD6,   1, 0, 32'h0,   2, 2));
        v1.push_back(mk(0, 0, 32'h0,    1, 0, I_ADD6,  0, 0));
        v1.push_back(mk(0, 0, I_NOPI,   1, 0, 32'h0,   0, 0)); // x0
        v1.push_back(mk(0, 0, I_ADD600, 1, 0, I_NOPI,  0, 0));
        v1.push_back(mk(0, 0, 32'h0,    1, 0, I_ADD600,0, 0));
        v1.push_back(mk(0, 0, I_ADDI5,  1, 0, 32'h0,   0, 0)); // forward from oldest entry
        v1.push_back(mk(0, 0, I_NOPI,   1, 0, I_ADDI5, 0, 0));
        v1.push_back(mk(0, 0, I_NOPI,   1, 0, I_NOPI,  0, 0));
        v1.push_back(mk(0, 0, I_ADD6,   1, 0, I_NOPI,  3, 3));
        v1.push_back(mk(0, 0, I_ADDI5,  1, 0, I_ADD6,  0, 0)); // distinct sources, youngest wins
        v1.push_back(mk(0, 0, I_ADDI6,  1, 0, I_ADDI5, 0, 0));
        v1.push_back(mk(0, 0, I_ADD7,   1, 0, I_ADDI6, 2, 1));
        v1.push_back(mk(0, 0, 32'h0,    1, 0, I_ADD7,  0, 0));

        @(posedge clk);
        #1;
        foreach (v0[n]) apply(0, v0[n], n);
        foreach (v1[n]) apply(1, v1[n], n);

        // Stall-length measurement, no forwarding: RAW at distance 1.
        instr0 = I_ADDI5;
        @(posedge clk); #1;
        instr0 = I_ADD6;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (!stall0) break;
            cnt++;
            @(posedge clk); #1;
        end
        check("nofwd_stall_len", 0, cnt, 3);
        @(posedge clk); #1;
        instr0 = 32'h0;
        @(negedge clk);
        check("nofwd_issue_after_stall", 0, hz0, I_ADD6);

        // Stall-length measurement, forwarding: load-use.
        instr1 = I_LW5;
        @(posedge clk); #1;
        instr1 = I_ADD6;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (!stall1) break;
            cnt++;
            @(posedge clk); #1;
        end
        check("fwd_loaduse_len", 0, cnt, 1);
        check("fwd_loaduse_sel", 0, {30'b0, f11}, 32'd2);
        @(posedge clk); #1;
        instr1 = 32'h0;
        @(negedge clk);
        check("fwd_issue_after_stall", 0, hz1, I_ADD6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
